blinker_bank: RTL
=================

// Module: blinker_bank
// PURPOSE
//  Multi-channel programmable blinker: generalises the single toggle-on-enable blinker.
//  Adds per-channel mode (off/on/blink/one-shot pulse) and a programmable half-period.
//  A global advance enable gates all channels.
//  Sits beside the LED/status outputs; programmed by a simple single-cycle write port.
// PARAMETERS
//  CHANNELS  4  number of independent blinker channels (1..16)
//  CNT_W     8  width of half-period counter/register
//  CH_W      4  width of wr_ch_i; must satisfy 2**CH_W >= CHANNELS
// PORTS
//  system1000        in   1         clock, rising edge
//  system1000_rstn   in   1         reset, asynchronous, active-low
//  i_en              in   1         global advance enable; counters step only when 1
//  wr_en_i           in   1         write strobe (1 cycle)
//  wr_ch_i           in   CH_W      channel index for write
//  wr_mode_i         in   2         00 off, 01 on, 10 blink, 11 pulse
//  wr_period_i       in   CNT_W     half-period P; phase length = P+1 enabled cycles
//  s_o               out  CHANNELS  registered blinker outputs
//  busy_o            out  CHANNELS  1 while channel is in pulse mode
//  wr_err_o          out  1         1-cycle pulse: write to wr_ch_i >= CHANNELS
// BEHAVIOUR
//  Per-channel state: mode[1:0], period[CNT_W-1:0], cnt[CNT_W-1:0], s.
//  Reset (async, rstn=0): mode=off, period=0, cnt=0, s_o=0, busy_o=0, wr_err_o=0.
//   - Outputs clear immediately, without a clock edge.
//   - Mid-operation reset aborts blinks and pulses.
//  Write: wr_en_i=1 and wr_ch_i<CHANNELS at edge k loads mode and period, and sets cnt=0.
//   - s after the write: off->0, on->1, blink->0, pulse->1.
//   - New value visible on s_o after edge k (0 added latency).
//   - wr_ch_i>=CHANNELS: no state change; wr_err_o=1 for the next cycle only.
//  Advance: applies only on edges where i_en=1 and the channel is not being written.
//   - blink: if cnt==period -> cnt=0, s=~s; else cnt=cnt+1.
//     P=0 toggles every enabled cycle (legacy blinker behaviour).
//   - pulse: if cnt==period -> s=0, mode=off, cnt=0; else cnt=cnt+1.
//     Output stays high for exactly P+1 enabled cycles.
//   - off/on: cnt held 0, s held.
//  i_en=0: all cnt and s hold, including during a pulse.
//  Write vs terminal count on the same channel and edge: the write wins; the toggle/expiry is discarded.
//  Rewriting a running channel restarts its phase from cnt=0.
//  Counter compares with ==, never wraps past period; P=2**CNT_W-1 is legal.
//  busy_o[c] = (mode[c]==pulse), registered with the state.
// CONFIGURATION
//  BLINKER_SYNC_EN defined:
//   - Adds input port sync_i (1 bit, after wr_period_i).
//   - sync_i=1 at an edge: every blink-mode channel gets cnt=0 and s=0, independent of i_en.
//   - Phase-aligns all blinkers.
//   - Pulse/on/off channels are unaffected.
//   - A write to a channel on the same edge wins over sync for that channel.
//  BLINKER_SYNC_EN undefined: sync_i port absent; no alignment logic; all other behaviour identical.
// TESTING
//  (CHANNELS=4, CNT_W=8)
//  1. Reset: run ch0 blink, drop rstn between edges -> s_o=0000, busy_o=0000 immediately;
//     after release with no writes, outputs stay 0.
//  2. Write ch0 blink P=0, i_en=1 -> s_o[0] sequence 0,1,0,1 on consecutive edges.
//  3. Write ch1 blink P=3, i_en toggling 1,0 -> s_o[1] toggles every 4 enabled edges (8 clocks);
//     holds while i_en=0.
//  4. Write ch2 pulse P=2, i_en=1 -> s_o[2]=1 and busy_o[2]=1 for 3 edges, then 0/0.
//     Repeat with i_en=0 mid-pulse -> pulse stretches by the stalled cycles.
//  5. wr_ch_i=5 -> wr_err_o=1 for 1 cycle, s_o/busy_o unchanged.
//     Write ch1 on its terminal-count edge -> no toggle, cnt=0, new mode applied.
//  6. (BLINKER_SYNC_EN) ch0, ch1 blink P=1 offset by 2 cycles; sync_i=1 for one edge
//     -> both s=0, then toggle together every 2 edges; ch2 pulse unaffected.

Source files
------------

// File: rtl/blinker_bank.sv
// Multi-channel programmable blinker with off/on/blink/pulse modes and a per-channel half-period.
// Optional build macro BLINKER_SYNC_EN adds sync_i, which phase-aligns every blink-mode channel.
module blinker_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CH_W     = 4
) (
    input  logic                system1000,
    input  logic                system1000_rstn,
    input  logic                i_en,
    input  logic                wr_en_i,
    input  logic [CH_W-1:0]     wr_ch_i,
    input  logic [1:0]          wr_mode_i,
    input  logic [CNT_W-1:0]    wr_period_i,
`ifdef BLINKER_SYNC_EN
    input  logic                sync_i,
`endif
    output logic [CHANNELS-1:0] s_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic                wr_err_o
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PULSE = 2'b11
    } mode_t;

    mode_t                mode_q   [CHANNELS];
    mode_t                mode_d   [CHANNELS];
    logic [CNT_W-1:0]     period_q [CHANNELS];
    logic [CNT_W-1:0]     period_d [CHANNELS];
    logic [CNT_W-1:0]     cnt_q    [CHANNELS];
    logic [CNT_W-1:0]     cnt_d    [CHANNELS];
    logic [CHANNELS-1:0]  s_d;
    logic [CHANNELS-1:0]  busy_d;
    logic                 wr_err_d;
    logic                 sync_c;
    mode_t                wr_mode_c;

`ifdef BLINKER_SYNC_EN
    assign sync_c = sync_i;
`else
    assign sync_c = 1'b0;
`endif

    assign wr_mode_c = mode_t'(wr_mode_i);

    // Per-channel next state: write beats sync, sync beats advance.
    always_comb begin
        wr_err_d = wr_en_i && (32'(wr_ch_i) >= CHANNELS);
        s_d      = s_o;
        busy_d   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            mode_d[c]   = mode_q[c];
            period_d[c] = period_q[c];
            cnt_d[c]    = cnt_q[c];

            if (wr_en_i && (32'(wr_ch_i) == c)) begin
                mode_d[c]   = wr_mode_c;
                period_d[c] = wr_period_i;
                cnt_d[c]    = '0;
                s_d[c]      = (wr_mode_c == MODE_ON) || (wr_mode_c == MODE_PULSE);
            end else if (sync_c && (mode_q[c] == MODE_BLINK)) begin
                cnt_d[c] = '0;
                s_d[c]   = 1'b0;
            end else if (i_en) begin
                unique case (mode_q[c])
                    MODE_BLINK: begin
                        if (cnt_q[c] == period_q[c]) begin
                            cnt_d[c] = '0;
                            s_d[c]   = ~s_o[c];
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end
                    end
                    MODE_PULSE: begin
                        if (cnt_q[c] == period_q[c]) begin
                            cnt_d[c]  = '0;
                            s_d[c]    = 1'b0;
                            mode_d[c] = MODE_OFF;
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end
                    end
                    default: cnt_d[c] = '0;
                endcase
            end

            busy_d[c] = (mode_d[c] == MODE_PULSE);
        end
    end

    // State and output registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                mode_q[c]   <= MODE_OFF;
                period_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            s_o      <= '0;
            busy_o   <= '0;
            wr_err_o <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                mode_q[c]   <= mode_d[c];
                period_q[c] <= period_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            s_o      <= s_d;
            busy_o   <= busy_d;
            wr_err_o <= wr_err_d;
        end
    end

endmodule
